// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the parallel-port FIFO and its drain/serializer stages.
package fifo_stream_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_PAR_READ   = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_LOAD  = 2'd2,
    S_SHIFT = 2'd3
  } state_e;

endpackage

// File: rtl/fifo_read_serializer_if.sv
// FIFO read port plus single-word valid/ready output stream of the serializer.
interface fifo_read_serializer_if
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PAR_READ   = DEF_PAR_READ
);

  logic                           fifo_valid;
  logic                           fifo_ren;
  logic [PAR_READ*DATA_WIDTH-1:0] fifo_dout;
  logic [DATA_WIDTH-1:0]          out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic                           out_last;

  // master: the serializer; slave: FIFO plus consumer side
  modport master (
    input  fifo_valid, fifo_dout, out_ready,
    output fifo_ren, out_data, out_valid, out_last
  );

  modport slave (
    output fifo_valid, fifo_dout, out_ready,
    input  fifo_ren, out_data, out_valid, out_last
  );

endinterface

// File: rtl/fifo_read_serializer.sv
// Pops PAR_READ-word groups from the FIFO and replays them one word per
// valid/ready handshake, lowest word first, flagging the last word.
module fifo_read_serializer
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PAR_READ   = DEF_PAR_READ
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clear,
  fifo_read_serializer_if.master  bus,
  output logic                    busy
);

  localparam int unsigned IDX_W = $clog2(PAR_READ);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAR_READ - 1);

  typedef logic [PAR_READ-1:0][DATA_WIDTH-1:0] buf_t;

  state_e                state_q, state_d;
  buf_t                  buf_q, buf_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      idx_nxt_c;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  fifo_ren_q, fifo_ren_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;

  assign idx_nxt_c = idx_q + IDX_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      fifo_ren_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      fifo_ren_q  <= fifo_ren_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  // Next state; outputs are registered copies decoded from the next state
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;

    if (clear) begin
      state_d = S_IDLE;
      buf_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.fifo_valid) state_d = S_REQ;
        end
        S_REQ: begin
          state_d = S_LOAD;
        end
        S_LOAD: begin
          buf_d      = buf_t'(bus.fifo_dout);
          idx_d      = '0;
          out_data_d = bus.fifo_dout[DATA_WIDTH-1:0];
          state_d    = S_SHIFT;
        end
        S_SHIFT: begin
          if (bus.out_ready) begin
            if (idx_q == IDX_LAST) begin
              state_d = bus.fifo_valid ? S_REQ : S_IDLE;
            end else begin
              idx_d      = idx_nxt_c;
              out_data_d = buf_q[idx_nxt_c];
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    fifo_ren_d  = (state_d == S_REQ);
    out_valid_d = (state_d == S_SHIFT);
    out_last_d  = (state_d == S_SHIFT) && (idx_d == IDX_LAST);
    busy_d      = (state_d != S_IDLE);
  end

  assign bus.fifo_ren  = fifo_ren_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;

endmodule

// File: doc/fifo_read_serializer.md
# fifo_read_serializer

Downstream drain stage for the parallel-port FIFO. It watches the FIFO's `valid` flag and pulses `ren` to pop one group of `PAR_READ` words. It captures the FIFO's `dout` and then emits the words one per handshake on a single-word valid/ready stream. It decouples the FIFO's wide read port from a narrow consumer and marks the last word of each group.

## Interface

Parameters:
- `DATA_WIDTH`, 8, bits per word; must match the FIFO.
- `PAR_READ`, 2, words per FIFO read; must match the FIFO; ≥ 2.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `clear` in 1: synchronous flush, active-high.
- `fifo_valid` in 1: FIFO holds ≥ `PAR_READ` words.
- `fifo_ren` out 1: one-cycle read strobe to the FIFO.
- `fifo_dout` in `PAR_READ*DATA_WIDTH`: FIFO read data; word 0 is in bits `[DATA_WIDTH-1:0]`.
- `out_data` out `DATA_WIDTH`: current serial word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts the word.
- `out_last` out 1: the current word is word `PAR_READ-1` of its group.
- `busy` out 1: state ≠ IDLE.

## Operation

- **Reset values:** state IDLE; `fifo_ren`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0; buffer and index cleared.
- **FSM states:** IDLE → REQ → LOAD → SHIFT.
- **IDLE:**
  - `fifo_valid`=1 and `clear`=0 → REQ.
  - Otherwise stay in IDLE.
- **REQ:**
  - `fifo_ren`=1 for exactly this one cycle (Moore output).
  - → LOAD unconditionally.
- **LOAD:**
  - The FIFO presents registered read data during this cycle.
  - At the end of the cycle, the full `fifo_dout` vector is captured into the buffer and the index is set to 0.
  - → SHIFT.
- **SHIFT:**
  - `out_valid`=1 and `out_data` = buffer word[index], lowest word first.
  - `out_last`=1 iff index = `PAR_READ-1`.
  - Handshake completes on a rising edge with `out_valid` & `out_ready`. On completion, index increments and `out_data` shows the next word in the following cycle.
  - When the last word completes: `fifo_valid`=1 → REQ, else → IDLE.
- **Stream rule:** while `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable. `out_valid` never drops before acceptance, except on `clear` or reset.
- **No early pop:** `fifo_ren` is never asserted outside REQ. No further pop is issued until all `PAR_READ` words of the current group are accepted.
- **`clear`:**
  - Highest synchronous priority, effective in any state.
  - Next state is IDLE; `out_valid`/`out_last` drop the next cycle; the buffer is discarded.
  - A pop already issued in REQ is not undone; its data is dropped.
- **Async reset mid-operation:** outputs go to their reset values immediately; no partial group is emitted afterwards.
- **Index width:** `$clog2(PAR_READ)`. The index never wraps inside SHIFT; it is reset in LOAD.

## Timing

- **Latency:** `fifo_valid` rising in cycle t (while IDLE) gives `fifo_ren` in t+1 and `out_valid` with word 0 in t+3.
- **Best-case group period** (`out_ready` held at 1, `fifo_valid` held at 1): `PAR_READ`+2 cycles, i.e. `PAR_READ` words then a 2-cycle REQ/LOAD bubble.
- **`fifo_valid` sampling:** sampled only in IDLE and on the last-word acceptance edge. A deassertion during REQ/LOAD does not abort the sequence, since the FIFO has already committed the pop.
- **Combinational paths:** `fifo_ren`, `out_valid`, `out_last` and `busy` are decoded from registered state only. There is no combinational path from `out_ready` or `fifo_valid` to any output.

## Structure

- **Shared package `fifo_stream_pkg`:**
  - state encodings `S_IDLE`, `S_REQ`, `S_LOAD`, `S_SHIFT` (2-bit);
  - default `DATA_WIDTH`/`PAR_READ`, shared with the FIFO and its benches.
- **Implementation:** single module, no sub-module. Contents: FSM register, `PAR_READ*DATA_WIDTH` buffer, index counter, output decode.

## Test plan

Default parameters unless stated.

1. **Basic group:** reset, then `fifo_valid`=1 for one group with `fifo_dout`={8'h34,8'hAC} in LOAD, `out_ready`=1.
   - `fifo_ren` high for exactly 1 cycle.
   - `out_data` 8'hAC, then 8'h34; `out_last` only on 8'h34; then `busy`=0.
2. **Backpressure:** as test 1, but `out_ready`=0 for 3 cycles on word 0.
   - 8'hAC with `out_valid`=1 is held stable for all 3 cycles.
   - No second `fifo_ren` until 8'h34 is accepted.
3. **Back-to-back:** `fifo_valid` held at 1 and two groups supplied, {8'h89,8'h23} then {8'h1D,8'hAB}.
   - Output order: 23, 89, AB, 1D.
   - Second `fifo_ren` exactly 1 cycle after 89 is accepted.
4. **Clear in SHIFT:** `clear` pulsed while 8'hAC is pending.
   - `out_valid`=0 the next cycle; 8'h34 is never emitted; state IDLE.
5. **Async reset mid-LOAD:** `rstn`=0 asserted mid-cycle.
   - All outputs 0 immediately.
   - After release with `fifo_valid`=0: no `fifo_ren` and no output.
6. **PAR_READ=4:** group {8'hA2,8'h34,8'h98,8'hAC}.
   - Output AC, 98, 34, A2; `out_last` only on A2; period 6 cycles with `out_ready`=1.
